// File: rtl/loader_pkg.sv
// Shared FSM encoding, error codes and frame constants for the instruction-memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_HDR0,
        ST_HDR1,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } loader_state_t;

    localparam logic [1:0] LD_ERR_NONE  = 2'b00;
    localparam logic [1:0] LD_ERR_COUNT = 2'b01;
    localparam logic [1:0] LD_ERR_CSUM  = 2'b10;

    localparam int LD_HDR_BYTES = 2;

endpackage

// File: rtl/word_assembler.sv
// Packs four accepted bytes little-endian into a word; o_word_vld fires combinationally with the 4th byte.
// No backpressure of its own: it consumes whatever i_vld presents; i_clr restarts the byte count.
module word_assembler (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_clr,
    input  logic        i_vld,
    input  logic [7:0]  i_byte,
    output logic        o_word_vld,
    output logic [31:0] o_word
);
    logic [1:0]  r_idx;
    logic [23:0] r_bytes;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idx   <= 2'd0;
            r_bytes <= 24'd0;
        end else if (i_clr) begin
            r_idx <= 2'd0;
        end else if (i_vld) begin
            r_idx <= r_idx + 2'd1;
            case (r_idx)
                2'd0:    r_bytes[7:0]   <= i_byte;
                2'd1:    r_bytes[15:8]  <= i_byte;
                2'd2:    r_bytes[23:16] <= i_byte;
                default: ;
            endcase
        end
    end

    assign o_word_vld = i_vld && !i_clr && (r_idx == 2'd3);
    assign o_word     = {i_byte, r_bytes};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> registered imem writes one cycle after each word's last byte; core held in reset until checksum matches.
// in_ready is high only in header/data/checksum states, so the host stalls in WAIT, DONE and ERR.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  done,
    output logic [1:0]            error
);
    loader_state_t         r_state;
    logic [7:0]            r_cnt_lo;
    logic [7:0]            r_csum;
    logic [15:0]           r_count;
    logic [16:0]           r_widx;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_core_reset;
    logic                  r_done;
    logic [1:0]            r_error;

    logic                  w_accept;
    logic [15:0]           w_count;
    logic                  w_last;
    logic                  w_clr;
    logic                  w_word_vld;
    logic [31:0]           w_word;

    assign in_ready = (r_state == ST_HDR0) || (r_state == ST_HDR1) ||
                      (r_state == ST_DATA) || (r_state == ST_CHK);
    assign w_accept = in_valid && in_ready;
    assign w_count  = {in_data, r_cnt_lo};
    assign w_last   = (r_widx == ({1'b0, r_count} - 17'd1));
    assign w_clr    = reload && ((r_state == ST_DONE) || (r_state == ST_ERR));

    word_assembler u_asm (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_clr      (w_clr),
        .i_vld      (w_accept && (r_state == ST_DATA)),
        .i_byte     (in_data),
        .o_word_vld (w_word_vld),
        .o_word     (w_word)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_WAIT;
            r_cnt_lo     <= 8'd0;
            r_csum       <= 8'd0;
            r_count      <= 16'd0;
            r_widx       <= 17'd0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            r_core_reset <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= LD_ERR_NONE;
        end else begin
            r_we <= w_word_vld;
            if (w_word_vld) begin
                // Wrap past the top of memory is intentional: only N is bounded, not BASE_ADDR+N.
                r_addr  <= ADDR_WIDTH'(BASE_ADDR) + r_widx[ADDR_WIDTH-1:0];
                r_wdata <= w_word;
            end
            case (r_state)
                ST_WAIT: r_state <= ST_HDR0;
                ST_HDR0: if (w_accept) begin
                    r_cnt_lo <= in_data;
                    r_csum   <= r_csum ^ in_data;
                    r_state  <= ST_HDR1;
                end
                ST_HDR1: if (w_accept) begin
                    r_csum  <= r_csum ^ in_data;
                    r_count <= w_count;
                    if ({1'b0, w_count} > (17'd1 << ADDR_WIDTH)) begin
                        r_state <= ST_ERR;
                        r_error <= LD_ERR_COUNT;
                    end else if (w_count == 16'd0) begin
                        r_state <= ST_CHK;
                    end else begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: if (w_accept) begin
                    r_csum <= r_csum ^ in_data;
                    if (w_word_vld) begin
                        r_widx <= r_widx + 17'd1;
                        if (w_last) r_state <= ST_CHK;
                    end
                end
                ST_CHK: if (w_accept) begin
                    if (in_data == r_csum) begin
                        r_state      <= ST_DONE;
                        r_done       <= 1'b1;
                        r_core_reset <= 1'b0;
                    end else begin
                        r_state <= ST_ERR;
                        r_error <= LD_ERR_CSUM;
                    end
                end
                ST_DONE, ST_ERR: if (reload) begin
                    r_state      <= ST_HDR0;
                    r_csum       <= 8'd0;
                    r_widx       <= 17'd0;
                    r_done       <= 1'b0;
                    r_error      <= LD_ERR_NONE;
                    r_core_reset <= 1'b1;
                end
                default: r_state <= ST_WAIT;
            endcase
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign core_reset = r_core_reset;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised frame stimulus against a queue-based reference; two loaders (base 0 and base 0xFF) share the stimulus.
module tb_imem_loader;
    import loader_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        reload = 1'b0;

    logic        rdy0, we0, crst0, done0;
    logic [7:0]  addr0;
    logic [31:0] data0;
    logic [1:0]  err0;
    logic        rdy1, we1, crst1, done1;
    logic [7:0]  addr1;
    logic [31:0] data1;
    logic [1:0]  err1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] words[$];
    logic [7:0]  frame[$];
    logic [39:0] exp0[$];
    logic [39:0] exp1[$];
    int          we_cyc[$];

    imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut0 (
        .clock(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .reload(reload), .imem_we(we0), .imem_addr(addr0),
        .imem_wdata(data0), .core_reset(crst0), .done(done0), .error(err0)
    );

    imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(255)) dut1 (
        .clock(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .reload(reload), .imem_we(we1), .imem_addr(addr1),
        .imem_wdata(data1), .core_reset(crst1), .done(done1), .error(err1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, want);
        end
    endtask

    // Scoreboard monitor: every write strobe pops the next expected {addr, data}.
    always @(negedge clk) begin
        if (reset_n && we0) begin
            we_cyc.push_back(cyc);
            if (exp0.size() == 0) chk("unexpected_write0", {56'd0, addr0}, 64'hFFFF);
            else chk("write0", {addr0, data0}, exp0.pop_front());
        end
        if (reset_n && we1) begin
            if (exp1.size() == 0) chk("unexpected_write1", {56'd0, addr1}, 64'hFFFF);
            else chk("write1", {addr1, data1}, exp1.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic make_frame(input int n, input logic [7:0] flip);
        logic [7:0] x;
        logic [31:0] w;
        frame.delete();
        frame.push_back(n[7:0]);
        frame.push_back(n[15:8]);
        for (int i = 0; i < n && i < words.size(); i++) begin
            w = words[i];
            for (int k = 0; k < 4; k++) frame.push_back(w[8*k +: 8]);
        end
        x = 8'd0;
        foreach (frame[i]) x = x ^ frame[i];
        frame.push_back(x ^ flip);
    endtask

    task automatic push_writes(input int k);
        for (int i = 0; i < k; i++) begin
            exp0.push_back({8'(i % 256), words[i]});
            exp1.push_back({8'((255 + i) % 256), words[i]});
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int g = 0;
        int n = 0;
        while (gap > 0 && $urandom_range(99) < gap && g < 4) begin
            in_valid = 1'b0;
            @(negedge clk);
            g++;
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!rdy0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy0) chk("in_ready_timeout", {63'd0, rdy0}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_bytes(input int cnt, input int gap);
        for (int i = 0; i < cnt && i < frame.size(); i++) send_byte(frame[i], gap);
    endtask

    task automatic check_status(input string tag, input logic want_done, input logic [1:0] want_err);
        int n = 0;
        while (!done0 && err0 == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done0"}, {63'd0, done0}, {63'd0, want_done});
        chk({tag, "_error0"}, {62'd0, err0}, {62'd0, want_err});
        chk({tag, "_core_reset0"}, {63'd0, crst0}, {63'd0, !want_done});
        chk({tag, "_in_ready0"}, {63'd0, rdy0}, 64'd0);
        chk({tag, "_done1"}, {63'd0, done1}, {63'd0, want_done});
        chk({tag, "_error1"}, {62'd0, err1}, {62'd0, want_err});
        chk({tag, "_core_reset1"}, {63'd0, crst1}, {63'd0, !want_done});
        chk({tag, "_pending0"}, 64'(exp0.size()), 64'd0);
        chk({tag, "_pending1"}, 64'(exp1.size()), 64'd0);
    endtask

    // Reload is asserted together with a stray in_valid byte, which must be ignored.
    task automatic do_reload(input string tag);
        reload   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        @(negedge clk);
        reload   = 1'b0;
        in_valid = 1'b0;
        chk({tag, "_reload_core_reset"}, {63'd0, crst0}, 64'd1);
        chk({tag, "_reload_done"}, {63'd0, done0}, 64'd0);
        chk({tag, "_reload_error"}, {62'd0, err0}, 64'd0);
        chk({tag, "_reload_in_ready"}, {63'd0, rdy1}, 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {62'd0, rdy0, rdy1}, 64'd0);
        chk({tag, "_we"}, {62'd0, we0, we1}, 64'd0);
        chk({tag, "_addr"}, {48'd0, addr0, addr1}, 64'd0);
        chk({tag, "_wdata"}, {data0, data1}, 64'd0);
        chk({tag, "_core_reset"}, {62'd0, crst0, crst1}, 64'd3);
        chk({tag, "_done"}, {62'd0, done0, done1}, 64'd0);
        chk({tag, "_error"}, {60'd0, err0, err1}, 64'd0);
    endtask

    task automatic run_frame(input string tag, input int n, input logic [7:0] flip, input int gap);
        logic [1:0] want_err;
        make_frame(n, flip);
        if (n > 256) begin
            want_err = LD_ERR_COUNT;
            send_bytes(LD_HDR_BYTES, gap);
        end else begin
            want_err = (flip != 8'd0) ? LD_ERR_CSUM : LD_ERR_NONE;
            push_writes(n);
            send_bytes(frame.size(), gap);
        end
        check_status(tag, want_err == LD_ERR_NONE, want_err);
    endtask

    initial begin
        int n;
        logic [7:0] flip;

        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        #1;
        chk("wait_in_ready", {63'd0, rdy0}, 64'd0);
        @(negedge clk);
        chk("hdr0_in_ready", {63'd0, rdy0}, 64'd1);

        words = '{32'h00A00513, 32'h00100593};
        run_frame("nominal", 2, 8'h00, 0);
        chk("nominal_write_count", 64'(we_cyc.size()), 64'd2);
        if (we_cyc.size() == 2) chk("nominal_write_spacing", 64'(we_cyc[1] - we_cyc[0]), 64'd4);

        do_reload("one_word");
        words = '{$urandom};
        run_frame("one_word", 1, 8'h00, 0);

        do_reload("zero");
        words.delete();
        run_frame("zero", 0, 8'h00, 0);

        do_reload("csum");
        words = '{32'h00A00513, 32'h00100593};
        run_frame("csum", 2, 8'h01, 0);

        do_reload("ovf");
        words.delete();
        run_frame("ovf", 257, 8'h00, 0);

        do_reload("full");
        words.delete();
        for (int i = 0; i < 256; i++) words.push_back($urandom);
        run_frame("full", 256, 8'h00, 0);

        for (int r = 0; r < 4; r++) begin
            do_reload("rand");
            n = $urandom_range(8, 1);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom);
            flip = ($urandom_range(2) == 0) ? 8'(1 << $urandom_range(7)) : 8'h00;
            run_frame("rand", n, flip, 30);
        end

        do_reload("stall");
        words = '{32'h00A00513, 32'h00100593};
        make_frame(2, 8'h00);
        push_writes(1);
        send_bytes(LD_HDR_BYTES + 5, 40);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        run_frame("resend", 2, 8'h00, 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the RISC-V pipeline. It receives a framed byte stream over a valid/ready interface and writes the payload as 32-bit words into instruction memory. While loading it holds the core in reset, and it releases the core only after the frame checksum is verified. It sits between the host/test stimulus port and the instruction-memory write port, at the top level beside `RISCV_Pipeline`.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: instruction-memory word-address width; capacity is 2**ADDR_WIDTH words.
- `BASE_ADDR`, 0: first word address written.

Ports:
- `clock`, in, 1: single clock. All logic is rising-edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: byte available.
- `in_data`, in, 8: stream byte.
- `in_ready`, out, 1: loader accepts a byte this cycle.
- `reload`, in, 1: single-cycle pulse that restarts loading; honoured only in DONE or ERR.
- `imem_we`, out, 1: instruction-memory write strobe.
- `imem_addr`, out, ADDR_WIDTH: word address.
- `imem_wdata`, out, 32: instruction word.
- `core_reset`, out, 1: active-high reset driven to the pipeline.
- `done`, out, 1: load completed and checksum matched.
- `error`, out, 2: 00 none, 01 count overflow, 10 checksum mismatch.

## Operation
- Frame format:
  - `CNT_LO`, `CNT_HI`: 16-bit word count N, little-endian.
  - 4·N payload bytes, each word little-endian (first byte goes to bits 7:0).
  - `CSUM`: XOR of every preceding frame byte, header included.
- A byte is accepted on a rising edge where `in_valid && in_ready`.
- FSM states: `WAIT`, `HDR0`, `HDR1`, `DATA`, `CHK`, `DONE`, `ERR`.
  - `WAIT` → `HDR0`: unconditionally, one cycle after reset release.
  - `HDR0` → `HDR1`: on accept; latch the count low byte.
  - `HDR1` → next state, on accept:
    - → `ERR` (error=01) if N > 2**ADDR_WIDTH.
    - → `CHK` if N = 0.
    - → `DATA` otherwise.
  - `DATA`: 2-bit byte counter assembles the word. On the 4th byte, issue a write and increment the word index. After word N-1, go to `CHK`.
  - `CHK` → `DONE` if the received byte equals the running XOR; otherwise → `ERR` (error=10).
  - `DONE`/`ERR` → `HDR0` on `reload`. This clears the XOR accumulator, word index, byte counter, `done` and `error`.
- `in_ready` = 1 exactly in `HDR0`, `HDR1`, `DATA`, `CHK`.
- `core_reset` = 1 in every state except `DONE`.
  - On checksum failure the core stays in reset.
  - Memory contents already written are not erased.
- Address arithmetic: `imem_addr` = `BASE_ADDR` + word index, truncated to ADDR_WIDTH. Wrap past the top of memory is permitted, since the count check bounds N, not `BASE_ADDR`+N.
- `in_valid` low stalls the FSM in its current state with no side effects.

## Timing
- Reset values: `in_ready` 0, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `core_reset` 1, `done` 0, `error` 00.
- First byte can be accepted on the 2nd rising edge after `reset_n` rises (the `WAIT` cycle).
- Write latency:
  - `imem_we`, `imem_addr` and `imem_wdata` are registered.
  - They are valid for exactly one cycle, starting after the edge that accepted byte 3 of the word.
  - Back-to-back bytes give a peak rate of one write per 4 cycles.
- `done`, `error` and `core_reset` are registered. They change on the edge that accepts the `CSUM` byte and are visible the same cycle the FSM enters `DONE`/`ERR`.
- `reload` and `in_valid` on the same edge in `DONE`: only `reload` acts, because `in_ready` is 0 in `DONE`.
- `reset_n` asserted mid-frame:
  - All outputs return to reset values asynchronously.
  - The partial frame is discarded, and the next frame starts from `CNT_LO`.
  - A write in flight (`imem_we` high) is cancelled.

## Structure
- Shared package `loader_pkg`:
  - FSM state encoding `loader_state_t`.
  - Error codes `LD_ERR_NONE`, `LD_ERR_COUNT`, `LD_ERR_CSUM`.
  - Frame constant `LD_HDR_BYTES`=2.
- One sub-module, `word_assembler`: byte counter plus 32-bit shift/assemble register. It emits a word-valid pulse and takes a clear input. The FSM, checksum and address counter stay in `imem_loader`.

## Test plan
- Nominal load:
  - Stimulus: frame 02 00 | 13 05 A0 00 | 93 05 10 00 | csum, with in_valid held high.
  - Required: writes (addr 0, 0x00A00513), then (addr 1, 0x00100593); `done`=1, `core_reset`=0, `error`=00.
- Zero count:
  - Stimulus: 00 00 00.
  - Required: no `imem_we`; `done`=1 after 3 accepted bytes.
- Overflow:
  - Stimulus: ADDR_WIDTH=8, count bytes 01 01 (N=257).
  - Required: `ERR`, `error`=01, `in_ready`=0, `core_reset` stays 1, no writes.
- Checksum error:
  - Stimulus: nominal frame with the csum byte XOR 0x01.
  - Required: both writes occur, `error`=10, `done`=0, `core_reset`=1.
- Stall and reset:
  - Stimulus: random `in_valid` gaps during the nominal frame. Then `reset_n` low after 5 payload bytes, then the full frame resent.
  - Required: identical writes as the nominal case; the aborted frame produces no write for word 1.
- Reload:
  - Stimulus: from `DONE`, pulse `reload`, then a one-word frame with BASE_ADDR=0xFF and ADDR_WIDTH=8.
  - Required: `core_reset` returns to 1 immediately; write at addr 0xFF; `done` again.
